// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - N-requester arbiter for the register file's single write port
// ARB_FIXED_PRIORITY_EN selects lowest-index-wins priority; default is round-robin.
module reg_write_arbiter #(
    parameter int W = 8,
    parameter int D = 4,
    parameter int N = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [N-1:0]   Req,
    input  logic [N*D-1:0] ReqAddr,
    input  logic [N*W-1:0] ReqData,
    input  logic           Hold,
    input  logic           ClrCnt,
    output logic [N-1:0]   Gnt,
    output logic           WriteEn,
    output logic [D-1:0]   Waddr,
    output logic [W-1:0]   DataIn,
    output logic [7:0]     ConflictCnt
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] win_idx;
    logic          granted;
    logic          contention;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        Gnt     = '0;
        win_idx = '0;
        granted = 1'b0;
        if (!Hold) begin
            for (int i = 0; i < N; i++) begin
                if (Req[i] && !granted) begin
                    Gnt[i]  = 1'b1;
                    win_idx = IW'(i);
                    granted = 1'b1;
                end
            end
        end
    end
`else
    logic [IW-1:0] last;
    logic [IW-1:0] cand;

    // Search starts one past the previous winner and wraps modulo N.
    always_comb begin
        Gnt     = '0;
        win_idx = '0;
        granted = 1'b0;
        cand    = '0;
        if (!Hold) begin
            for (int k = 1; k <= N; k++) begin
                cand = IW'((int'(last) + k) % N);
                if (Req[cand] && !granted) begin
                    Gnt[cand] = 1'b1;
                    win_idx   = cand;
                    granted   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last <= IW'(N - 1);
        end else if (granted) begin
            last <= win_idx;
        end
    end
`endif

    assign contention = !Hold && ($countones(Req) > 1);

    // Registered output stage: no combinational path from Req to the register file.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            WriteEn <= 1'b0;
            Waddr   <= '0;
            DataIn  <= '0;
        end else if (granted) begin
            WriteEn <= 1'b1;
            Waddr   <= ReqAddr[int'(win_idx)*D +: D];
            DataIn  <= ReqData[int'(win_idx)*W +: W];
        end else begin
            WriteEn <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ConflictCnt <= 8'd0;
        end else if (ClrCnt) begin
            ConflictCnt <= 8'd0;
        end else if (contention && ConflictCnt != 8'hFF) begin
            ConflictCnt <= ConflictCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed and randomized checks of reg_write_arbiter against a reference model
module tb_reg_write_arbiter;
    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 3;

    logic           Clk = 1'b0;
    logic           Reset;
    logic [N-1:0]   Req;
    logic [N*D-1:0] ReqAddr;
    logic [N*W-1:0] ReqData;
    logic           Hold;
    logic           ClrCnt;
    logic [N-1:0]   Gnt;
    logic           WriteEn;
    logic [D-1:0]   Waddr;
    logic [W-1:0]   DataIn;
    logic [7:0]     ConflictCnt;

    int checks = 0;
    int errors = 0;

    int             m_last;
    logic           m_we;
    logic [D-1:0]   m_addr;
    logic [W-1:0]   m_data;
    int             m_cnt;

    logic [W-1:0]   rf [2**D];

    reg_write_arbiter #(.W(W), .D(D), .N(N)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .Hold(Hold), .ClrCnt(ClrCnt), .Gnt(Gnt), .WriteEn(WriteEn), .Waddr(Waddr),
        .DataIn(DataIn), .ConflictCnt(ConflictCnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (WriteEn) rf[Waddr] <= DataIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (Hold || Req == '0) return g;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (Req[i]) begin g[i] = 1'b1; return g; end
`else
        for (int k = 1; k <= N; k++) if (Req[(m_last + k) % N]) begin
            g[(m_last + k) % N] = 1'b1;
            return g;
        end
`endif
        return g;
    endfunction

    task automatic model_reset();
        m_last = N - 1; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
    endtask

    // Checks one cycle mid-period, then advances the model across the ending edge.
    task automatic cycle(output logic [N-1:0] g);
        logic [N-1:0] eg;
        int w;
        #4;
        eg = exp_gnt();
        g  = Gnt;
        chk("gnt", Gnt, eg);
        chk("write_en", WriteEn, m_we);
        chk("waddr", Waddr, m_addr);
        chk("data_in", DataIn, m_data);
        chk("conflict_cnt", ConflictCnt, m_cnt);
        @(posedge Clk);
        if (ClrCnt) m_cnt = 0;
        else if (!Hold && $countones(Req) >= 2 && m_cnt < 255) m_cnt++;
        w = -1;
        for (int i = 0; i < N; i++) if (eg[i]) w = i;
        if (w >= 0) begin
            m_we = 1'b1;
            m_addr = ReqAddr[w*D +: D];
            m_data = ReqData[w*W +: W];
            m_last = w;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Req = '0; Hold = 1'b0; ClrCnt = 1'b0;
        #1;
        chk("rst_write_en", WriteEn, 1'b0);
        chk("rst_waddr", Waddr, '0);
        chk("rst_data_in", DataIn, '0);
        chk("rst_conflict_cnt", ConflictCnt, 8'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] rr_exp [6];
        logic [N-1:0] hold_exp [4];
        ReqAddr = '0; ReqData = '0;
        model_reset();

        // Reset state
        do_reset();

        // Single request from requester 1
        Req = 3'b010; ReqAddr[1*D +: D] = 4'h5; ReqData[1*W +: W] = 8'hA7;
        cycle(g);
        chk("single_gnt", g, 3'b010);
        Req = '0;
        cycle(g);
        cycle(g);

        // All three requesting continuously
        do_reset();
`ifdef ARB_FIXED_PRIORITY_EN
        rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        hold_exp = '{3'b000, 3'b000, 3'b001, 3'b001};
`else
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        hold_exp = '{3'b000, 3'b000, 3'b001, 3'b100};
`endif
        Req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            cycle(g);
            chk($sformatf("rr_gnt_%0d", c), g, rr_exp[c]);
        end
        Req = '0;
        cycle(g);
        chk("rr_conflict_cnt", ConflictCnt, 8'd6);

        // Hold suppresses grants and contention counting
        do_reset();
        Req = 3'b101;
        for (int c = 0; c < 4; c++) begin
            Hold = (c < 2);
            cycle(g);
            chk($sformatf("hold_gnt_%0d", c), g, hold_exp[c]);
        end
        Hold = 1'b0; Req = '0;
        cycle(g);
        chk("hold_conflict_cnt", ConflictCnt, 8'd2);

        // Saturation then clear under contention
        do_reset();
        Req = 3'b111;
        for (int c = 0; c < 300; c++) cycle(g);
        chk("sat_conflict_cnt", ConflictCnt, 8'd255);
        ClrCnt = 1'b1;
        cycle(g);
        ClrCnt = 1'b0; Req = '0;
        cycle(g);
        chk("clr_conflict_cnt", ConflictCnt, 8'd0);

        // Reset asserted while a loaded write is being presented
        do_reset();
        Req = 3'b001; ReqAddr[0 +: D] = 4'h3; ReqData[0 +: W] = 8'h5A;
        cycle(g);
        Req = '0;
        #2;
        chk("pre_rst_write_en", WriteEn, 1'b1);
        chk("pre_rst_waddr", Waddr, 4'h3);
        do_reset();
        Req = 3'b110;
        cycle(g);
        chk("post_rst_gnt", g, 3'b010);
        Req = '0;
        cycle(g);

        // Requester 2 writes address 0; visible two cycles after the grant
        do_reset();
        Req = 3'b100; ReqAddr[2*D +: D] = 4'h0; ReqData[2*W +: W] = 8'h3C;
        cycle(g);
        Req = '0;
        cycle(g);
        chk("e2e_rf0", rf[0], 8'h3C);

        // Randomized traffic with requesters holding until granted
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!Req[i] && $urandom_range(1, 0) == 1) begin
                    Req[i] = 1'b1;
                    ReqAddr[i*D +: D] = D'($urandom);
                    ReqData[i*W +: W] = W'($urandom);
                end
            end
            Hold   = ($urandom_range(3, 0) == 0);
            ClrCnt = ($urandom_range(15, 0) == 0);
            cycle(g);
            Req = Req & ~g;
        end
        Hold = 1'b0; ClrCnt = 1'b0; Req = '0;
        cycle(g);
        cycle(g);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

- Shares the register file's single write port among `N` requesters (for example ALU result, data-memory load and immediate loader).
- Each cycle it selects one pending request, by round-robin or by compile-time fixed priority, and returns a one-hot grant.
- The winner's address and data go into a registered output stage that drives the register file's `WriteEn`/`Waddr`/`DataIn` directly.
- It also counts write-port contention cycles for performance tuning.

## Interface
- `W`, 8, data path width (matches register file).
- `D`, 4, register address width (2**D registers).
- `N`, 3, number of write requesters (2..8).
- `Clk`  input  1  rising-edge clock.
- `Reset`  input  1  asynchronous, active-high reset.
- `Req`  input  N  request bit per requester; held with address/data until granted.
- `ReqAddr`  input  N*D  packed addresses; requester i at bits [i*D +: D].
- `ReqData`  input  N*W  packed data; requester i at bits [i*W +: W].
- `Hold`  input  1  pipeline stall; suppresses all grants this cycle.
- `ClrCnt`  input  1  synchronous clear of `ConflictCnt`.
- `Gnt`  output  N  one-hot (or zero) grant, combinational, same cycle as selection.
- `WriteEn`  output  1  registered write enable to register file.
- `Waddr`  output  D  registered write address.
- `DataIn`  output  W  registered write data.
- `ConflictCnt`  output  8  saturating count of contention cycles.

## Operation
- **Selection.** When `Hold`=0 and any `Req` bit is set, exactly one `Gnt` bit is asserted. When `Hold`=1 or `Req`=0, `Gnt`=0.
- **Round-robin.**
  - Pointer `Last` holds the index of the last winner.
  - Search order is `Last`+1, `Last`+2, … modulo N.
  - `Last` updates only on a cycle with a grant.
  - Reset value of `Last` is N-1, so requester 0 wins first.
- **Handshake.**
  - A request is consumed on the rising edge ending a cycle with `Req[i]`=1 and `Gnt[i]`=1.
  - The requester may change address/data or drop `Req` after that edge.
  - An ungranted requester holds `Req`, address and data stable; the arbiter never drops a pending request.
- **Output stage.**
  - On a grant edge: `WriteEn`←1, `Waddr`←winner address, `DataIn`←winner data.
  - On any edge with no grant: `WriteEn`←0, and `Waddr`/`DataIn` hold their previous values.
- **Contention.** `ConflictCnt` increments on each edge where popcount(`Req`)≥2 and `Hold`=0. It saturates at 255. `ClrCnt` takes precedence over increment.
- **Address 0.** Address 0 is an ordinary writable register; no special handling.
- **Same-address writes.** Back-to-back grants to the same address are legal; the later grant's data is written last.
- **Reset** (asynchronous, any time, including mid-grant):
  - `WriteEn`=0, `Waddr`=0, `DataIn`=0, `ConflictCnt`=0, `Last`=N-1.
  - A grant in flight during reset is lost; requesters must re-present.

## Timing
- **Cycle t:** `Req` seen, `Gnt` asserted combinationally (no registered delay).
- **Edge ending t:** request consumed; output stage loaded.
- **Cycle t+1:** `WriteEn`/`Waddr`/`DataIn` valid at the register-file inputs.
- **Edge ending t+1:** register file written. New value is readable combinationally in cycle t+2.
- **Throughput:** one write per cycle. With all N requesting continuously, each is granted once every N cycles (round-robin mode).
- **Hold:** `Hold` affects only the cycle it is asserted; an output-stage write already loaded still completes.
- **Path:** `Gnt` depends combinationally on `Req` and `Hold`; no combinational path from `Req` to `WriteEn`/`Waddr`/`DataIn`.

## Configuration
- `ARB_FIXED_PRIORITY_EN` defined: fixed priority, lowest index wins. `Last` is not implemented (or is held at reset value). A continuously requesting requester 0 starves all others.
- `ARB_FIXED_PRIORITY_EN` undefined (default): round-robin as described above.

## Test plan
- **Single request.** Reset, then `Req`=3'b010, addr 4'h5, data 8'hA7 for one cycle.
  - Same cycle: `Gnt`=3'b010.
  - Next cycle: `WriteEn`=1, `Waddr`=5, `DataIn`=8'hA7.
  - Following cycle: `WriteEn`=0.
- **Round-robin.** `Req`=3'b111 held for 6 cycles.
  - `Gnt` sequence 001, 010, 100, 001, 010, 100.
  - `ConflictCnt`=6.
  - With `ARB_FIXED_PRIORITY_EN`: `Gnt`=001 all 6 cycles.
- **Hold.** `Req`=3'b101 with `Hold`=1 for 2 cycles, then `Hold`=0.
  - `Gnt`=0 and `WriteEn`=0 during the hold.
  - Then 001, 100.
  - `ConflictCnt` increments only on the 2 unheld cycles.
- **Saturation and clear.** 300 contention cycles → `ConflictCnt`=255. Then `ClrCnt`=1 with contention present → 0.
- **Reset mid-operation.** Assert `Reset` in the cycle after a grant to addr 3. `WriteEn`, `Waddr`, `DataIn` go to 0 immediately (asynchronously). After release, `Req`=3'b110 → `Gnt`=010 first (`Last`=N-1 restored).
- **End-to-end.** Arbiter driving a register file, requester 2 writes 8'h3C to addr 0. Read port A at addr 0 returns 8'h3C two cycles after grant.
